vx_shift_pipe_arbiter: RTL and testbench
========================================

# vx_shift_pipe_arbiter

Shares one fixed-latency DEPTH-stage delay pipeline among NUM_REQS requesters. Requests are arbitrated round-robin and tagged with the requester index. The pipeline stalls globally when its output is held off. It is the issue/retire controller placed in front of shared fixed-latency units, such as multi-cycle ALU stages, that are built on the team's shift-register primitive.

## Interface
- NUM_REQS, 4, number of requesters, ≥1
- DATAW, 32, payload width, ≥1
- DEPTH, 3, pipeline stages (latency), ≥1
- TAGW, max(1, $clog2(NUM_REQS)), tag width, derived
- CNTW, $clog2(DEPTH+1), occupancy counter width, derived
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQS  per-requester request valid
- req_data  in  NUM_REQS*DATAW  payloads; requester i at [i*DATAW +: DATAW]
- req_ready  out  NUM_REQS  one-hot-or-zero accept
- rsp_valid  out  1  output stage holds a valid entry
- rsp_data  out  DATAW  output payload
- rsp_tag  out  TAGW  index of the originating requester
- rsp_ready  in  1  downstream accept
- count  out  CNTW  number of valid entries in the pipeline
- busy  out  1  count != 0

## Operation
- Each stage s (0..DEPTH-1) holds {valid, tag, data}.
  - Only valid is reset. tag and data are don't-care while valid=0.
- Stall: stall = rsp_valid & ~rsp_ready. advance = ~stall.
- On advance:
  - Stage s takes stage s-1.
  - Stage 0 takes {fire, grant_idx, req_data[grant_idx]}.
  - Internal bubbles do not collapse; they shift like entries.
- rsp_valid, rsp_tag and rsp_data are stage DEPTH-1 outputs.
- With rsp_valid=0, the pipeline advances regardless of rsp_ready.
- Arbitration, with rr_ptr a TAGW-bit register:
  - grant_idx is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_REQS.
  - req_ready[i] = advance & any(req_valid) & (i == grant_idx).
  - req_ready[i] is never 1 while req_valid[i]=0.
  - fire = |(req_valid & req_ready).
  - On fire, rr_ptr <= (grant_idx+1) mod NUM_REQS. Otherwise rr_ptr holds.
  - NUM_REQS=1: rr_ptr and rsp_tag are constant 0.
- Occupancy: count is +1 on fire without retire, -1 on retire (rsp_valid & rsp_ready) without fire, unchanged on both or neither.
  - count equals the popcount of stage valids at all times and never exceeds DEPTH.
- Reset, asserted asynchronously at any time including mid-stream:
  - All stage valids, count and rr_ptr go to 0 immediately.
  - rsp_valid, busy and req_ready go to 0 without waiting for a clock edge.
  - In-flight entries are discarded, not delivered.
- Outputs after reset: rsp_valid=0, rsp_tag/rsp_data don't-care, req_ready=0 until the first cycle with reset low, count=0, busy=0.

## Timing
- Latency: a request fired at edge E appears on rsp_valid in the cycle after edge E+DEPTH-1, i.e. DEPTH cycles. Each stall cycle adds exactly one cycle.
- Throughput: one request per cycle when rsp_ready=1 or the output stage is empty.
- Combinational paths:
  - rsp_ready → req_ready, through stall.
  - req_valid → req_ready, through the arbiter.
  - Neither req_data nor rsp_ready affects rsp_* in the same cycle.
- During stall:
  - rsp_valid, rsp_tag and rsp_data are held stable.
  - All req_ready are 0.
  - rr_ptr and count hold.
- Simultaneous fire and retire on the same edge: both occur and count is unchanged.

## Test plan
- Async reset: with count=3, assert reset between edges → rsp_valid=0, busy=0, count=0, req_ready=0 before the next edge. Deassert, then requesters 0 and 2 valid → requester 0 granted first (rr_ptr=0).
- Single request (NUM_REQS=4, DEPTH=3): req_valid[1] with data 0xA5 accepted at cycle 0, rsp_ready=1 → rsp_valid=1 in cycle 3 only, rsp_data=0xA5, rsp_tag=1, count 1 for cycles 1–3.
- Fairness: all four req_valid held high, rsp_ready=1 → grants 0,1,2,3,0,1… one per cycle. rsp_tag sequence is the same, starting at cycle 3. count saturates at 3.
- Backpressure: full pipeline, rsp_ready=0 for 5 cycles → req_ready=0, rsp_* stable, count=3. After release, the remaining tags continue in order with no loss or duplication.
- Bubbles: fires at cycles 0 and 2 only, rsp_ready=0 from cycle 3 → the entry from cycle 0 stalls at the output. The cycle-2 entry stays two stages behind with the bubble preserved, and count=2 during the stall.
- Skip: only requesters 3 and 1 valid, rr_ptr=2 → grant 3, then 1, then 3; requesters 0 and 2 never see req_ready.

Source files
------------

// File: rtl/vx_shift_pipe_arbiter.sv
// Round-robin issue/retire controller in front of a shared DEPTH-stage fixed-latency pipeline.
// Entries carry the requester index as a tag, and the whole pipe stalls when the output is held off.
module vx_shift_pipe_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int DEPTH    = 3,
    parameter int TAGW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int CNTW     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      rsp_valid,
    output logic [DATAW-1:0]          rsp_data,
    output logic [TAGW-1:0]           rsp_tag,
    input  logic                      rsp_ready,
    output logic [CNTW-1:0]           count,
    output logic                      busy
);

    logic                 stall;
    logic                 advance;
    logic                 any_valid;
    logic                 fire;
    logic                 retire;
    logic [TAGW-1:0]      rr_ptr;
    logic [TAGW-1:0]      grant_idx;
    logic [CNTW-1:0]      count_q;
    logic [DEPTH-1:0]     stage_valid;
    logic [TAGW-1:0]      stage_tag  [DEPTH];
    logic [DATAW-1:0]     stage_data [DEPTH];

    // Requester index (a + b) mod NUM_REQS; both operands are already below NUM_REQS.
    function automatic logic [TAGW-1:0] wrap_add(input logic [TAGW-1:0] a, input int b);
        int sum;
        sum = int'(a) + b;
        if (sum >= NUM_REQS)
            sum = sum - NUM_REQS;
        return TAGW'(sum);
    endfunction

    assign stall     = rsp_valid & ~rsp_ready;
    assign advance   = ~stall;
    assign any_valid = |req_valid;
    assign retire    = rsp_valid & rsp_ready;
    assign fire      = |(req_valid & req_ready);

    // Scan from the farthest candidate back to rr_ptr so the nearest valid requester wins.
    // NOTE: every always_comb output gets a default before any branch; otherwise a latch is inferred.
    always_comb begin
        grant_idx = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr, k)])
                grant_idx = wrap_add(rr_ptr, k);
        end
    end

    // Gated by reset so nothing is offered while the pipeline is being cleared.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQS; i++)
            req_ready[i] = ~reset & advance & any_valid & (grant_idx == TAGW'(i));
    end

    // NOTE: sequential state is written only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (fire)
            rr_ptr <= wrap_add(grant_idx, 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid <= '0;
        end else if (advance) begin
            stage_valid[0] <= fire;
            for (int s = 1; s < DEPTH; s++)
                stage_valid[s] <= stage_valid[s-1];
        end
    end

    // NOTE: tag/data are qualified by stage_valid, so they are left unreset to keep them plain flops.
    always_ff @(posedge clk) begin
        if (advance) begin
            stage_tag[0]  <= grant_idx;
            stage_data[0] <= req_data[int'(grant_idx)*DATAW +: DATAW];
            for (int s = 1; s < DEPTH; s++) begin
                stage_tag[s]  <= stage_tag[s-1];
                stage_data[s] <= stage_data[s-1];
            end
        end
    end

    // Tracks the popcount of stage_valid without an adder tree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else if (fire && !retire)
            count_q <= count_q + CNTW'(1);
        else if (retire && !fire)
            count_q <= count_q - CNTW'(1);
    end

    assign rsp_valid = stage_valid[DEPTH-1];
    assign rsp_tag   = stage_tag[DEPTH-1];
    assign rsp_data  = stage_data[DEPTH-1];
    assign count     = count_q;
    assign busy      = (count_q != '0);

endmodule

// File: tb/tb_vx_shift_pipe_arbiter.sv
// Directed bench: stimulus pushes expected {tag, data} per grant; a negedge monitor checks the output stage.
module tb_vx_shift_pipe_arbiter;

    localparam int NUM_REQS = 4;
    localparam int DATAW    = 32;
    localparam int DEPTH    = 3;
    localparam int TAGW     = 2;
    localparam int CNTW     = 2;

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [DATAW-1:0] data;
    } rsp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS*DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]       req_ready;
    logic                      rsp_valid;
    logic [DATAW-1:0]          rsp_data;
    logic [TAGW-1:0]           rsp_tag;
    logic                      rsp_ready;
    logic [CNTW-1:0]           count;
    logic                      busy;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;

    vx_shift_pipe_arbiter #(
        .NUM_REQS(NUM_REQS), .DATAW(DATAW), .DEPTH(DEPTH), .TAGW(TAGW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATAW-1:0] data_of(input int s, input int i);
        return 32'hA500_0000 + 32'(s * 256) + 32'(i * 16) + 32'h5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check at negedge, push the hand-computed grant, then cross the edge.
    task automatic step(input logic [3:0] v, input logic rr, input logic [3:0] exp_rdy,
                        input int exp_cnt, input logic exp_rv);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < NUM_REQS; i++)
            req_data[i*DATAW +: DATAW] = data_of(seq, i);
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("count", 32'(count), 32'(exp_cnt));
        check("busy", 32'(busy), 32'(exp_cnt != 0));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        for (int i = 0; i < NUM_REQS; i++)
            if (exp_rdy[i])
                exp_q.push_back('{tag: TAGW'(i), data: data_of(seq, i)});
        seq++;
        @(posedge clk);
        #1;
    endtask

    // Head of the queue must be on the output whenever it is valid, stalled or not.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got tag %0d data %h expected no response at %0t",
                         rsp_tag, rsp_data, $time);
            end else begin
                check("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
                check("rsp_data", rsp_data, exp_q[0].data);
                if (rsp_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;

        // Single request from requester 1: visible in cycle 3 only.
        step(4'b0010, 1'b1, 4'b0010, 0, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 1, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 1, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 1, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0);

        // Skip: rr_ptr=2, only requesters 3 and 1 valid.
        step(4'b1010, 1'b1, 4'b1000, 0, 1'b0);
        step(4'b1010, 1'b1, 4'b0010, 1, 1'b0);
        step(4'b1010, 1'b1, 4'b1000, 2, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 3, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 2, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0);

        // Fairness with all requesters, then 5 stall cycles, then release and drain.
        for (int k = 0; k < 8; k++)
            step(4'b1111, 1'b1, 4'(1 << (k % 4)), (k < 3) ? k : 3, k >= 3);
        for (int k = 0; k < 5; k++)
            step(4'b1111, 1'b0, 4'b0000, 3, 1'b1);
        for (int k = 0; k < 4; k++)
            step(4'b1111, 1'b1, 4'(1 << k), 3, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 3, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 2, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0);

        // Bubbles: fires in cycles 0 and 2, output stalled from cycle 3; the gap must survive.
        step(4'b0001, 1'b1, 4'b0001, 0, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 1, 1'b0);
        step(4'b0100, 1'b1, 4'b0100, 1, 1'b0);
        for (int k = 0; k < 4; k++)
            step(4'b1111, 1'b0, 4'b0000, 2, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 2, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 1, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0);

        // Fill to count=3 (rr_ptr=3), stall, then assert reset between edges.
        step(4'b1111, 1'b1, 4'b1000, 0, 1'b0);
        step(4'b1111, 1'b1, 4'b0001, 1, 1'b0);
        step(4'b1111, 1'b1, 4'b0010, 2, 1'b0);
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("full_count", 32'(count), 32'd3);
        check("full_req_ready", 32'(req_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        rsp_ready = 1'b1;

        // After reset rr_ptr=0: requester 0 first, then 2; nothing stale may emerge.
        step(4'b0101, 1'b1, 4'b0001, 0, 1'b0);
        step(4'b0101, 1'b1, 4'b0100, 1, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 2, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 2, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 0, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
